ir_queue: RTL
=============

Name: ir_queue

Overview:
- Parametrised successor to the single-entry instruction register: a DEPTH-entry instruction prefetch queue with built-in field decode.
- Sits between instruction RAM read data (Ram_Inst_Out) and the control unit.
- Accepts instructions with a valid/ready handshake and presents the head entry already split into Opcode, Source_Reg1, Source_Reg2 and Dest_Reg.
- Supports a synchronous flush for branches.

Parameters:
- INST_WIDTH, 21: instruction width; must equal OPCODE_WIDTH + 3*ADDR_WIDTH (elaboration-time check, $error on mismatch).
- OPCODE_WIDTH, 3: opcode field width, taken from the top bits.
- ADDR_WIDTH, 6: width of each register-address field.
- DEPTH, 4: number of queue entries; power of two, minimum 2.
- CNT_WIDTH, $clog2(DEPTH+1): width of the Count output (derived; not overridden).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- Flush  in  1  discard all entries (synchronous).
- In_Valid  in  1  Ram_Inst_Out holds a valid instruction.
- In_Ready  out  1  queue can accept this cycle.
- Ram_Inst_Out  in  INST_WIDTH  instruction read from RAM.
- Out_Valid  out  1  head entry valid.
- Out_Ready  in  1  consumer takes the head entry this cycle.
- Inst_Out  out  INST_WIDTH  raw head instruction.
- Opcode  out  OPCODE_WIDTH  head bits [INST_WIDTH-1 -: OPCODE_WIDTH], i.e. [20:18].
- Source_Reg1  out  ADDR_WIDTH  head bits [17:12].
- Source_Reg2  out  ADDR_WIDTH  head bits [11:6].
- Dest_Reg  out  ADDR_WIDTH  head bits [5:0].
- Count  out  CNT_WIDTH  occupied entries, 0..DEPTH.
- Full  out  1  Count == DEPTH.
- Empty  out  1  Count == 0.

Behaviour:
- Reset (Reset_n=0 at a rising edge):
  - wr_ptr, rd_ptr and Count go to 0.
  - Empty=1, Full=0, In_Ready=1, Out_Valid=0.
  - All data outputs are 0.
  - Storage contents are not cleared.
  - Reset mid-operation drops every entry; it has priority over Flush, push and pop.
- Push: occurs when In_Valid && In_Ready.
  - Writes mem[wr_ptr] and increments wr_ptr modulo DEPTH (natural wrap).
- Pop: occurs when Out_Valid && Out_Ready.
  - Increments rd_ptr modulo DEPTH.
- In_Ready = ~Full. A push is refused on a full queue even when a pop happens in the same cycle; there is no full-queue pass-through.
- Out_Valid = ~Empty (base build).
- Latency: an instruction pushed at edge N appears on the outputs after edge N, provided the queue was empty.
- Push and pop in the same cycle (neither Full nor Empty): Count is unchanged and both pointers advance.
- Count arithmetic:
  - Count_next = Count + push - pop, computed in CNT_WIDTH bits.
  - It never exceeds DEPTH and never underflows, because push and pop are gated by In_Ready and Out_Valid.
- Data outputs are driven from mem[rd_ptr], masked to 0 while Out_Valid=0, so waveform dumps stay deterministic.
- Flush (Reset_n=1, Flush=1):
  - Next state: both pointers 0 and Count 0.
  - A push or pop in the flush cycle is ignored.
  - Outputs read as empty from the next cycle.
- Out_Ready while Empty has no effect. In_Valid while Full holds off the producer; the producer keeps Ram_Inst_Out stable.
- The design has no state machine beyond the pointers and counter. The state is defined by (Count, rd_ptr, wr_ptr).

Optional Feature:
- Macro: IRQ_BYPASS_EN.
- Defined:
  - When Empty && In_Valid && ~Flush, Out_Valid=1 in the same cycle.
  - Inst_Out and all fields are decoded directly from Ram_Inst_Out.
  - If Out_Ready=1 in that cycle, the instruction is consumed with no write and Count stays 0.
  - If Out_Ready=0, it is written normally (Count becomes 1).
- Not defined: Out_Valid = ~Empty only, and the minimum latency is one cycle.

Decomposition:
- Shared parameters file (existing parameters.v) gains:
  - IRQ_DEPTH default.
  - Field-position constants OPCODE_LSB=18, SR1_LSB=12, SR2_LSB=6, DR_LSB=0.
  - NUM_IRQ_TEST.
- INST_WIDTH, OPCODE_WIDTH and ADDR_WIDTH are reused from the existing file.
- One natural sub-module: inst_field_decode, a combinational INST_WIDTH-to-fields splitter. It is shared with the legacy IR and instanced once on the head data (and once on the bypass path when enabled).

Test Plan:
- Reset then push 21'b101_000001_000010_000011 with Out_Ready=0 -> next cycle Out_Valid=1, Opcode=101, Source_Reg1=1, Source_Reg2=2, Dest_Reg=3, Count=1.
- Push 4 distinct instructions (DEPTH=4) with Out_Ready=0 -> Full=1, In_Ready=0, Count=4; a 5th push is refused; popping 4 returns them in order and ends with Empty=1 and all fields 0.
- Hold In_Valid=1 and Out_Ready=1 continuously for 10 cycles from Count=2 -> Count stays 2 and output order matches input order, including pointer wrap past entry 3.
- Fill to Count=3, then assert Flush together with In_Valid=1 and Out_Ready=1 -> next cycle Count=0, Out_Valid=0, and the flush-cycle instruction is not stored.
- Reset_n=0 asserted while Count=3 -> next cycle Count=0, Empty=1, Opcode=0; a subsequent push appears after 1 cycle.
- IRQ_BYPASS_EN: with Empty, In_Valid=1, Out_Ready=1 -> same-cycle Out_Valid=1 with decoded fields, and Count stays 0. Without the macro, the same stimulus gives Out_Valid=0 that cycle and 1 the next.

Source files
------------

// File: rtl/ir_queue_pkg.sv
// Shared constants for the instruction prefetch queue and field decoder.
// Field layout: opcode | source reg 1 | source reg 2 | destination reg.
package ir_queue_pkg;

  localparam int INST_WIDTH   = 21;
  localparam int OPCODE_WIDTH = 3;
  localparam int ADDR_WIDTH   = 6;

  localparam int IRQ_DEPTH    = 4;

  localparam int OPCODE_LSB   = 18;
  localparam int SR1_LSB      = 12;
  localparam int SR2_LSB      = 6;
  localparam int DR_LSB       = 0;

  localparam int NUM_IRQ_TEST = 6;

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/ir_queue_field_decode.sv
// Combinational splitter from a raw instruction word into its fields.
// Shared by the legacy instruction register and the prefetch queue.
module inst_field_decode
  import ir_queue_pkg::*;
#(
  parameter int INST_WIDTH   = ir_queue_pkg::INST_WIDTH,
  parameter int OPCODE_WIDTH = ir_queue_pkg::OPCODE_WIDTH,
  parameter int ADDR_WIDTH   = ir_queue_pkg::ADDR_WIDTH
) (
  input  logic [INST_WIDTH-1:0]   inst,
  output logic [OPCODE_WIDTH-1:0] opcode,
  output logic [ADDR_WIDTH-1:0]   src_reg1,
  output logic [ADDR_WIDTH-1:0]   src_reg2,
  output logic [ADDR_WIDTH-1:0]   dest_reg
);

  assign opcode   = inst[INST_WIDTH-1 -: OPCODE_WIDTH];
  assign src_reg1 = inst[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign src_reg2 = inst[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign dest_reg = inst[ADDR_WIDTH-1 -: ADDR_WIDTH];

endmodule

// File: rtl/ir_queue.sv
// DEPTH-entry instruction prefetch queue with decoded head fields.
// Optional same-cycle empty-queue bypass: define IRQ_BYPASS_EN.
module ir_queue
  import ir_queue_pkg::*;
#(
  parameter int INST_WIDTH   = ir_queue_pkg::INST_WIDTH,
  parameter int OPCODE_WIDTH = ir_queue_pkg::OPCODE_WIDTH,
  parameter int ADDR_WIDTH   = ir_queue_pkg::ADDR_WIDTH,
  parameter int DEPTH        = IRQ_DEPTH,
  parameter int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    Flush,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  input  logic [INST_WIDTH-1:0]   Ram_Inst_Out,
  output logic                    Out_Valid,
  input  logic                    Out_Ready,
  output logic [INST_WIDTH-1:0]   Inst_Out,
  output logic [OPCODE_WIDTH-1:0] Opcode,
  output logic [ADDR_WIDTH-1:0]   Source_Reg1,
  output logic [ADDR_WIDTH-1:0]   Source_Reg2,
  output logic [ADDR_WIDTH-1:0]   Dest_Reg,
  output logic [CNT_WIDTH-1:0]    Count,
  output logic                    Full,
  output logic                    Empty
);

  localparam int PTR_W = $clog2(DEPTH);

  if (INST_WIDTH != OPCODE_WIDTH + 3 * ADDR_WIDTH) begin : g_bad_width
    $error("ir_queue: INST_WIDTH must equal OPCODE_WIDTH + 3*ADDR_WIDTH");
  end
  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("ir_queue: DEPTH must be a power of two and at least 2");
  end

  logic [INST_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  push;
  logic                  pop;
  logic                  byp_sel;
  logic                  byp_take;
  logic [INST_WIDTH-1:0] head;

  assign Count    = cnt;
  assign Full     = (cnt == CNT_WIDTH'(DEPTH));
  assign Empty    = (cnt == '0);
  assign In_Ready = ~Full;

`ifdef IRQ_BYPASS_EN
  assign byp_sel = Empty & In_Valid & ~Flush;
`else
  assign byp_sel = 1'b0;
`endif

  assign Out_Valid = ~Empty | byp_sel;
  assign byp_take  = byp_sel & Out_Ready;

  // A bypassed instruction consumed this cycle never lands in storage.
  assign push = In_Valid & In_Ready & ~byp_take;
  assign pop  = ~Empty & Out_Ready;

  always_comb begin
    head = '0;
    if (byp_sel)
      head = Ram_Inst_Out;
    else if (!Empty)
      head = mem[rd_ptr];
  end

  assign Inst_Out = head;

  inst_field_decode #(
    .INST_WIDTH   (INST_WIDTH),
    .OPCODE_WIDTH (OPCODE_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_head_dec (
    .inst     (head),
    .opcode   (Opcode),
    .src_reg1 (Source_Reg1),
    .src_reg2 (Source_Reg2),
    .dest_reg (Dest_Reg)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge Clk) begin
    if (Reset_n && !Flush && push)
      mem[wr_ptr] <= Ram_Inst_Out;
  end

endmodule
